lfsr_gen: RTL and testbench



---
 rtl/lfsr_gen.sv | 135 +++++++++++++
 tb/tb_lfsr_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load, zero-lockup recovery and wrap flag.
// Optional macro LFSR_PERIOD_EN adds a 32-bit measured sequence period output.
module lfsr_gen #(
   parameter int              WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS = 8'hB8,
   parameter int              MODE  = 0,
   parameter int              STEPS = 1,
   parameter logic [WIDTH-1:0] SEED = 8'h01
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] state,
   output logic             bit_out,
   output logic             lockup,
   output logic             zero_seed,
   output logic             wrap
`ifdef LFSR_PERIOD_EN
   ,
   output logic [31:0]      period
`endif
);

   logic [WIDTH-1:0] r_state;
   logic [WIDTH-1:0] r_seed;
   logic             r_bit;
   logic             r_lockup;
   logic             r_zero_seed;
   logic             r_wrap;

   logic [WIDTH-1:0] w_adv;
   logic [WIDTH-1:0] w_state_next;
   logic [WIDTH-1:0] w_seed_next;
   logic             w_lockup_next;
   logic             w_zero_seed_next;
   logic             w_wrap_next;

   function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] s);
      if (MODE == 0)
         return {s[WIDTH-2:0], ^(s & TAPS)};
      else
         return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : '0);
   endfunction

   // STEPS single steps unrolled into one combinational advance
   always_comb begin
      w_adv = r_state;
      for (int k = 0; k < STEPS; k++)
         w_adv = f_step(w_adv);
   end

   always_comb begin
      w_state_next     = r_state;
      w_seed_next      = r_seed;
      w_lockup_next    = 1'b0;
      w_zero_seed_next = 1'b0;
      w_wrap_next      = 1'b0;
      if (load) begin
         if (seed_in != '0) begin
            w_state_next = seed_in;
            w_seed_next  = seed_in;
         end else begin
            w_state_next     = SEED;
            w_seed_next      = SEED;
            w_zero_seed_next = 1'b1;
         end
      end else if (en) begin
         if (r_state == '0) begin
            w_state_next  = SEED;
            w_lockup_next = 1'b1;
         end else begin
            w_state_next = w_adv;
            w_wrap_next  = (w_adv == r_seed);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= SEED;
         r_seed      <= SEED;
         r_bit       <= SEED[WIDTH-1];
         r_lockup    <= 1'b0;
         r_zero_seed <= 1'b0;
         r_wrap      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_seed      <= w_seed_next;
         r_bit       <= w_state_next[WIDTH-1];
         r_lockup    <= w_lockup_next;
         r_zero_seed <= w_zero_seed_next;
         r_wrap      <= w_wrap_next;
      end
   end

   assign state     = r_state;
   assign bit_out   = r_bit;
   assign lockup    = r_lockup;
   assign zero_seed = r_zero_seed;
   assign wrap      = r_wrap;

`ifdef LFSR_PERIOD_EN
   logic [31:0] r_cnt;
   logic [31:0] r_period;
   logic [32:0] w_cnt_sum;
   logic [31:0] w_cnt_inc;

   // saturating count so a pathological TAPS never rolls the period over
   assign w_cnt_sum = {1'b0, r_cnt} + 33'(STEPS);
   assign w_cnt_inc = w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_period <= '0;
      end else if (load) begin
         r_cnt <= '0;
      end else if (en) begin
         if (r_state == '0) begin
            r_cnt <= '0;
         end else if (w_adv == r_seed) begin
            r_period <= w_cnt_inc;
            r_cnt    <= '0;
         end else begin
            r_cnt <= w_cnt_inc;
         end
      end
   end

   assign period = r_period;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: four parameterisations driven in parallel against a
// bit-arithmetic reference model; directed checks plus randomized load/en/reset traffic.
module tb_lfsr_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   localparam int NI = 4;
   // instance 0: defaults, 1: Galois 0x71, 2: Fibonacci with no taps, 3: STEPS=4
   localparam logic [7:0] P_TAPS  [NI] = '{8'hB8, 8'h71, 8'h00, 8'hB8};
   localparam int         P_MODE  [NI] = '{0, 1, 0, 0};
   localparam int         P_STEPS [NI] = '{1, 1, 1, 4};

   logic       d_rst  [NI];
   logic       d_en   [NI];
   logic       d_load [NI];
   logic [7:0] d_seed [NI];

   logic [7:0]  o_state [NI];
   logic        o_bit   [NI];
   logic        o_lk    [NI];
   logic        o_zs    [NI];
   logic        o_wr    [NI];
   logic [31:0] o_per   [NI];

   lfsr_gen u_dflt (
      .clk(clk), .reset(d_rst[0]), .en(d_en[0]), .load(d_load[0]), .seed_in(d_seed[0]),
      .state(o_state[0]), .bit_out(o_bit[0]), .lockup(o_lk[0]), .zero_seed(o_zs[0]), .wrap(o_wr[0])
`ifdef LFSR_PERIOD_EN
      , .period(o_per[0])
`endif
   );

   lfsr_gen #(.WIDTH(8), .TAPS(8'h71), .MODE(1), .STEPS(1), .SEED(8'h01)) u_gal (
      .clk(clk), .reset(d_rst[1]), .en(d_en[1]), .load(d_load[1]), .seed_in(d_seed[1]),
      .state(o_state[1]), .bit_out(o_bit[1]), .lockup(o_lk[1]), .zero_seed(o_zs[1]), .wrap(o_wr[1])
`ifdef LFSR_PERIOD_EN
      , .period(o_per[1])
`endif
   );

   lfsr_gen #(.WIDTH(8), .TAPS(8'h00), .MODE(0), .STEPS(1), .SEED(8'h01)) u_tap0 (
      .clk(clk), .reset(d_rst[2]), .en(d_en[2]), .load(d_load[2]), .seed_in(d_seed[2]),
      .state(o_state[2]), .bit_out(o_bit[2]), .lockup(o_lk[2]), .zero_seed(o_zs[2]), .wrap(o_wr[2])
`ifdef LFSR_PERIOD_EN
      , .period(o_per[2])
`endif
   );

   lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .MODE(0), .STEPS(4), .SEED(8'h01)) u_s4 (
      .clk(clk), .reset(d_rst[3]), .en(d_en[3]), .load(d_load[3]), .seed_in(d_seed[3]),
      .state(o_state[3]), .bit_out(o_bit[3]), .lockup(o_lk[3]), .zero_seed(o_zs[3]), .wrap(o_wr[3])
`ifdef LFSR_PERIOD_EN
      , .period(o_per[3])
`endif
   );

`ifndef LFSR_PERIOD_EN
   initial for (int k = 0; k < NI; k++) o_per[k] = '0;
`endif

   typedef struct {
      int          k;
      logic [7:0]  st;
      logic        b;
      logic        lk;
      logic        zs;
      logic        wr;
      logic [31:0] per;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   logic [7:0] m_st  [NI];
   logic [7:0] m_sd  [NI];
   longint     m_cnt [NI];
   longint     m_per [NI];

   initial for (int k = 0; k < NI; k++) begin
      m_st[k] = 8'h01; m_sd[k] = 8'h01; m_cnt[k] = 0; m_per[k] = 0;
   end

   // one LFSR shift, by arithmetic: doubling mod 256 plus feedback parity / tap XOR
   function automatic logic [7:0] m_one(input logic [7:0] s, input logic [7:0] taps, input int mode);
      int v;
      int ones;
      v = (int'(s) * 2) % 256;
      if (mode == 0) begin
         ones = 0;
         for (int i = 0; i < 8; i++) if (s[i] && taps[i]) ones++;
         return 8'(v + (ones % 2));
      end
      return 8'(v) ^ ((int'(s) >= 128) ? taps : 8'h00);
   endfunction

   function automatic longint sat32(input longint v);
      return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end else begin
         $display("chk %s: %0h", nm, act);
      end
   endtask

   task automatic drive_all(input logic r, input logic e, input logic l, input logic [7:0] s);
      for (int k = 0; k < NI; k++) begin
         d_rst[k] = r; d_en[k] = e; d_load[k] = l; d_seed[k] = s;
      end
   endtask

   // predict the response to the inputs currently driven, queue it, advance one clock
   task automatic tick();
      exp_t       e;
      logic [7:0] nx;
      for (int k = 0; k < NI; k++) begin
         e.k = k; e.lk = 0; e.zs = 0; e.wr = 0;
         if (d_rst[k]) begin
            m_st[k] = 8'h01; m_sd[k] = 8'h01; m_cnt[k] = 0; m_per[k] = 0;
         end else if (d_load[k]) begin
            if (d_seed[k] != 0) begin
               m_st[k] = d_seed[k]; m_sd[k] = d_seed[k];
            end else begin
               m_st[k] = 8'h01; m_sd[k] = 8'h01; e.zs = 1;
            end
            m_cnt[k] = 0;
         end else if (d_en[k]) begin
            if (m_st[k] == 0) begin
               m_st[k] = 8'h01; e.lk = 1; m_cnt[k] = 0;
            end else begin
               nx = m_st[k];
               for (int j = 0; j < P_STEPS[k]; j++) nx = m_one(nx, P_TAPS[k], P_MODE[k]);
               m_st[k] = nx;
               if (nx == m_sd[k]) begin
                  e.wr = 1;
                  m_per[k] = sat32(m_cnt[k] + P_STEPS[k]);
                  m_cnt[k] = 0;
               end else begin
                  m_cnt[k] = sat32(m_cnt[k] + P_STEPS[k]);
               end
            end
         end
         e.st = m_st[k]; e.b = m_st[k][7]; e.per = 32'(m_per[k]);
         q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // monitor: every queued expectation is due one edge after it was issued
   always @(posedge clk) begin
      #1;
      while (q.size() > 0) begin
         exp_t e;
         logic [31:0] per_act;
         e = q.pop_front();
`ifdef LFSR_PERIOD_EN
         per_act = o_per[e.k];
`else
         per_act = e.per;
`endif
         n_vec++;
         if ({o_state[e.k], o_bit[e.k], o_lk[e.k], o_zs[e.k], o_wr[e.k], per_act} !==
             {e.st, e.b, e.lk, e.zs, e.wr, e.per}) begin
            n_err++;
            $display("FAIL sb[%0d]: got st=%h b=%b lk=%b zs=%b wr=%b per=%0d expected st=%h b=%b lk=%b zs=%b wr=%b per=%0d",
                     e.k, o_state[e.k], o_bit[e.k], o_lk[e.k], o_zs[e.k], o_wr[e.k], per_act,
                     e.st, e.b, e.lk, e.zs, e.wr, e.per);
         end
      end
   end

   initial begin
      logic [7:0] seq [4];
      int nw;
      int last;
      seq = '{8'h02, 8'h04, 8'h08, 8'h11};
      drive_all(1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);

      tick();
      chk("rst_state", o_state[0], 8'h01);
      chk("rst_bit", o_bit[0], 1'b0);
      chk("rst_pulses", {o_lk[0], o_zs[0], o_wr[0]}, 3'b000);

      drive_all(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("fib_seq", o_state[0], seq[i]);
         chk("fib_bit", o_bit[0], 1'b0);
         if (i == 0) chk("steps4", o_state[3], 8'h11);
      end

      drive_all(1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      drive_all(1'b0, 1'b1, 1'b0, 8'h00);
      nw = 0; last = 0;
      for (int i = 1; i <= 520; i++) begin
         tick();
         if (o_wr[0]) begin
            nw++;
            chk("wrap_state", o_state[0], 8'h01);
            chk("wrap_gap", 64'(i - last), 64'd255);
            last = i;
`ifdef LFSR_PERIOD_EN
            chk("period", o_per[0], 32'd255);
`endif
         end
      end
      chk("wrap_count", 64'(nw), 64'd2);

      drive_all(1'b0, 1'b0, 1'b1, 8'h80);
      tick();
      chk("gal_load", o_state[1], 8'h80);
      drive_all(1'b0, 1'b1, 1'b0, 8'h00);
      tick();
      chk("gal_step1", o_state[1], 8'h71);
      tick();
      chk("gal_step2", o_state[1], 8'hE2);

      drive_all(1'b0, 1'b1, 1'b1, 8'h5A);
      tick();
      chk("load_en_state", o_state[0], 8'h5A);
      chk("load_en_wrap", o_wr[0], 1'b0);
      drive_all(1'b0, 1'b1, 1'b0, 8'h00);
      tick();
      chk("after_load_step", o_state[0], 8'hB4);

      drive_all(1'b0, 1'b0, 1'b1, 8'h00);
      tick();
      chk("zero_seed_state", o_state[0], 8'h01);
      chk("zero_seed_pulse", o_zs[0], 1'b1);
      drive_all(1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      chk("zero_seed_clear", o_zs[0], 1'b0);

      drive_all(1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      drive_all(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) tick();
      chk("tap0_zero", o_state[2], 8'h00);
      chk("tap0_no_lockup", o_lk[2], 1'b0);
      tick();
      chk("lockup_state", o_state[2], 8'h01);
      chk("lockup_pulse", o_lk[2], 1'b1);

      for (int i = 0; i < 10; i++) tick();
      drive_all(1'b1, 1'b1, 1'b0, 8'h00);
      tick();
      chk("midrst_state", o_state[0], 8'h01);
      chk("midrst_pulses", {o_lk[0], o_zs[0], o_wr[0]}, 3'b000);
      chk("midrst_s4", o_state[3], 8'h01);

      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < NI; k++) begin
            d_rst[k]  = ($urandom_range(63) == 0);
            d_load[k] = ($urandom_range(15) == 0);
            d_en[k]   = ($urandom_range(3) != 0);
            d_seed[k] = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
         end
         tick();
      end

      drive_all(1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
